// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shared single-port memory arbiter for fetch and data requesters
//
// Purpose: grants one of two requesters (instruction fetch, data memory) access
// to a single-ported memory. Data has priority, but a fetch that has waited
// through STARVE_MAX consecutive data grants wins the next arbitration. Each
// access occupies ACCESS for MEM_LAT cycles, then one ACK cycle. A new
// arbitration can only happen in the IDLE cycle that follows.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   if_req/if_addr         fetch request (held until if_ack) and address
//   if_rdata/if_ack        registered fetch data, one-cycle completion pulse
//   dm_read/dm_write       data request kinds (both high is treated as write)
//   dm_addr/dm_wdata       data address and store data
//   dm_rdata/dm_ack        registered load data, one-cycle completion pulse
//   stall                  combinational pipeline freeze while a request waits
//   mem_en/mem_we          memory strobes, high in the first ACCESS cycle only
//   mem_addr/mem_wdata     latched access address and write data
//   mem_rdata              memory read data, captured in the last ACCESS cycle
module unified_mem_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  starve_q;
  logic        owner_dm_q;   // 1: data requester owns the current access
  logic        wr_q;
  logic        mem_en_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] dm_rdata_q;
  logic        if_ack_q;
  logic        dm_ack_q;

  logic        dm_req;
  logic        grant_if_d;
  logic        grant_dm_d;

  always_comb begin
    dm_req     = dm_read | dm_write;
    grant_if_d = if_req & (~dm_req | (starve_q == STARVE_LIM));
    grant_dm_d = ~grant_if_d & dm_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      starve_q    <= 4'd0;
      owner_dm_q  <= 1'b0;
      wr_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      dm_rdata_q  <= 32'd0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
    end else begin
      // Strobes and acks are single-cycle pulses unless re-asserted below.
      mem_en_q <= 1'b0;
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_if_d || grant_dm_d) begin
            state_q     <= ST_ACCESS;
            cnt_q       <= LAT_INIT;
            mem_en_q    <= 1'b1;
            owner_dm_q  <= grant_dm_d;
            wr_q        <= grant_dm_d & dm_write;
            mem_addr_q  <= grant_dm_d ? dm_addr : if_addr;
            mem_wdata_q <= dm_wdata;
            // Count only data grants that actually made a fetch wait.
            if (grant_if_d) begin
              starve_q <= 4'd0;
            end else if (if_req && (starve_q != STARVE_LIM)) begin
              starve_q <= starve_q + 4'd1;
            end
          end
        end
        ST_ACCESS: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= ST_ACK;
            if (!wr_q) begin
              if (owner_dm_q) begin
                dm_rdata_q <= mem_rdata;
              end else begin
                if_rdata_q <= mem_rdata;
              end
            end
            if (owner_dm_q) begin
              dm_ack_q <= 1'b1;
            end else begin
              if_ack_q <= 1'b1;
            end
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_en_q & wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign stall     = (if_req & ~if_ack_q) | (dm_req & ~dm_ack_q);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        stall;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .MEM_LAT   (2),
    .STARVE_MAX(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .dm_read  (dm_read),
    .dm_write (dm_write),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ack   (dm_ack),
    .stall    (stall),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Start a new cycle: inputs change 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Waits for either ack, starting in the current cycle; who: 0 fetch, 1 data.
  task automatic wait_ack(output int who, output int cyc);
    who = -1;
    cyc = -1;
    for (int i = 0; i < 20 && who < 0; i++) begin
      if (i > 0) next_cycle();
      @(negedge clk);
      if (if_ack || dm_ack) begin
        who = dm_ack ? 1 : 0;
        cyc = i;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int who;
  int cyc;
  int en_cnt;
  int exp_order [6] = '{1, 1, 0, 1, 1, 0};

  initial begin
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = 32'd0;
    dm_read   = 1'b0;
    dm_write  = 1'b0;
    dm_addr   = 32'd0;
    dm_wdata  = 32'd0;
    mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_if_ack", {31'd0, if_ack}, 32'd0);
    check("rst_dm_ack", {31'd0, dm_ack}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    next_cycle();
    rst = 1'b0;

    // Single fetch
    next_cycle();
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    check("sf_c0_stall", {31'd0, stall}, 32'd1);
    check("sf_c0_mem_en", {31'd0, mem_en}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("sf_c1_mem_en", {31'd0, mem_en}, 32'd1);
    check("sf_c1_mem_we", {31'd0, mem_we}, 32'd0);
    check("sf_c1_mem_addr", mem_addr, 32'h40);
    check("sf_c1_stall", {31'd0, stall}, 32'd1);
    next_cycle();
    mem_rdata = 32'h8C010004;
    @(negedge clk);
    check("sf_c2_mem_en", {31'd0, mem_en}, 32'd0);
    check("sf_c2_if_ack", {31'd0, if_ack}, 32'd0);
    check("sf_c2_stall", {31'd0, stall}, 32'd1);
    next_cycle();
    @(negedge clk);
    check("sf_c3_if_ack", {31'd0, if_ack}, 32'd1);
    check("sf_c3_dm_ack", {31'd0, dm_ack}, 32'd0);
    check("sf_c3_if_rdata", if_rdata, 32'h8C010004);
    check("sf_c3_stall", {31'd0, stall}, 32'd0);
    next_cycle();
    if_req = 1'b0;
    mem_rdata = 32'h0;
    @(negedge clk);
    check("sf_c4_if_ack", {31'd0, if_ack}, 32'd0);
    check("sf_c4_if_rdata_hold", if_rdata, 32'h8C010004);

    // Simultaneous requests: data first, then fetch
    next_cycle();
    if_req = 1'b1; if_addr = 32'h40;
    dm_read = 1'b1; dm_addr = 32'h100;
    mem_rdata = 32'h11111111;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("sim_c1_mem_en", {31'd0, mem_en}, 32'd1);
    check("sim_c1_mem_addr", mem_addr, 32'h100);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("sim_c3_dm_ack", {31'd0, dm_ack}, 32'd1);
    check("sim_c3_if_ack", {31'd0, if_ack}, 32'd0);
    check("sim_c3_dm_rdata", dm_rdata, 32'h11111111);
    check("sim_c3_stall", {31'd0, stall}, 32'd1);
    next_cycle();
    dm_read = 1'b0;
    mem_rdata = 32'h22222222;
    @(negedge clk);
    check("sim_c4_mem_en", {31'd0, mem_en}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("sim_c5_mem_en", {31'd0, mem_en}, 32'd1);
    check("sim_c5_mem_addr", mem_addr, 32'h40);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("sim_c7_if_ack", {31'd0, if_ack}, 32'd1);
    check("sim_c7_if_rdata", if_rdata, 32'h22222222);
    check("sim_c7_dm_rdata", dm_rdata, 32'h11111111);
    next_cycle();
    if_req = 1'b0;

    // Starvation: both held; order D D F D D F, one ack every 4 cycles
    next_cycle();
    if_req = 1'b1; if_addr = 32'h44;
    dm_read = 1'b1; dm_addr = 32'h104;
    mem_rdata = 32'h33333333;
    for (int k = 0; k < 6; k++) begin
      wait_ack(who, cyc);
      check($sformatf("starve_owner%0d", k), 32'(who), 32'(exp_order[k]));
      check($sformatf("starve_gap%0d", k), 32'(cyc), 32'd3);
      next_cycle();
    end
    if_req = 1'b0;
    dm_read = 1'b0;
    @(negedge clk);
    check("starve_dm_rdata", dm_rdata, 32'h33333333);
    check("starve_if_rdata", if_rdata, 32'h33333333);

    // Write
    next_cycle();
    dm_write = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
    mem_rdata = 32'hBAD0BAD0;
    en_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cycle();
      if (i == 4) dm_write = 1'b0;
      @(negedge clk);
      if (mem_en) en_cnt++;
      if (i == 1) begin
        check("wr_c1_mem_we", {31'd0, mem_we}, 32'd1);
        check("wr_c1_mem_addr", mem_addr, 32'h200);
        check("wr_c1_mem_wdata", mem_wdata, 32'hDEADBEEF);
      end
      if (i == 2) check("wr_c2_mem_we", {31'd0, mem_we}, 32'd0);
      if (i == 3) begin
        check("wr_c3_dm_ack", {31'd0, dm_ack}, 32'd1);
        check("wr_c3_mem_addr", mem_addr, 32'h200);
        check("wr_c3_mem_wdata", mem_wdata, 32'hDEADBEEF);
        check("wr_c3_dm_rdata", dm_rdata, 32'h33333333);
      end
    end
    check("wr_en_cycles", 32'(en_cnt), 32'd1);

    // Read-and-write conflict behaves as a write
    next_cycle();
    dm_read = 1'b1; dm_write = 1'b1; dm_addr = 32'h300; dm_wdata = 32'h0BADF00D;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("rw_c1_mem_we", {31'd0, mem_we}, 32'd1);
    check("rw_c1_mem_addr", mem_addr, 32'h300);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rw_c3_dm_ack", {31'd0, dm_ack}, 32'd1);
    check("rw_c3_dm_rdata", dm_rdata, 32'h33333333);
    next_cycle();
    dm_read = 1'b0; dm_write = 1'b0;

    // Reset mid-access
    next_cycle();
    if_req = 1'b1; if_addr = 32'h80;
    mem_rdata = 32'h55555555;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("rm_c1_mem_en", {31'd0, mem_en}, 32'd1);
    check("rm_c1_mem_addr", mem_addr, 32'h80);
    next_cycle();
    rst = 1'b1;
    #1;
    check("rm_mem_en", {31'd0, mem_en}, 32'd0);
    check("rm_mem_we", {31'd0, mem_we}, 32'd0);
    check("rm_mem_addr", mem_addr, 32'd0);
    check("rm_mem_wdata", mem_wdata, 32'd0);
    check("rm_if_rdata", if_rdata, 32'd0);
    check("rm_dm_rdata", dm_rdata, 32'd0);
    check("rm_if_ack", {31'd0, if_ack}, 32'd0);
    check("rm_dm_ack", {31'd0, dm_ack}, 32'd0);
    check("rm_stall", {31'd0, stall}, 32'd1);
    next_cycle();
    @(negedge clk);
    check("rm_c3_if_ack", {31'd0, if_ack}, 32'd0);
    next_cycle();
    rst = 1'b0;
    wait_ack(who, cyc);
    check("rm_restart_owner", 32'(who), 32'd0);
    check("rm_restart_lat", 32'(cyc), 32'd3);
    check("rm_restart_rdata", if_rdata, 32'h55555555);
    next_cycle();
    if_req = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
